hood_display_driver: RTL and testbench

Consumes the status and time values the range-hood top level produces and drives the board's 8-digit multiplexed seven-segment display. It converts 6-bit time values to two BCD digits and offers three selectable display pages. Inputs are snapshotted once per scan frame so a refresh never shows a torn value. The controller is power- and reminder-aware, and sits between the hood top level and the display pins.

---
 rtl/hood_display_driver.sv | 211 +++++++++++++++++++++
 tb/tb_hood_display_driver.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hood_display_driver.sv
// Range-hood 8-digit multiplexed seven-segment driver: three pages, per-frame input snapshot.
// Optional `DISP_REMIND_BLINK_EN blinks page 1 while the cleaning reminder is active.
module hood_display_driver #(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned BLINK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_on,
  input  logic       btn_page,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_second,
  input  logic [5:0] work_hours,
  input  logic [5:0] work_minutes,
  input  logic [3:0] state_smoke_lvl,
  input  logic [5:0] hand_time,
  input  logic       remind,
  output logic [7:0] an,
  output logic [7:0] seg
);
  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [7:0] GLYPH_DASH  = 8'h40;
  localparam logic [7:0] GLYPH_L     = 8'h38;
  localparam logic [7:0] GLYPH_H     = 8'h76;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  typedef enum logic [1:0] {PAGE_CLOCK, PAGE_WORK, PAGE_HAND} page_e;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'h0: return 8'h3F;
      4'h1: return 8'h06;
      4'h2: return 8'h5B;
      4'h3: return 8'h4F;
      4'h4: return 8'h66;
      4'h5: return 8'h6D;
      4'h6: return 8'h7D;
      4'h7: return 8'h07;
      4'h8: return 8'h7F;
      4'h9: return 8'h6F;
      4'hA: return 8'h77;
      4'hB: return 8'h7C;
      4'hC: return 8'h39;
      4'hD: return 8'h5E;
      4'hE: return 8'h79;
      default: return 8'h71;
    endcase
  endfunction

  function automatic logic [7:0] tens_glyph(input logic [5:0] v);
    return digit_glyph(4'(v / 6'd10));
  endfunction

  function automatic logic [7:0] ones_glyph(input logic [5:0] v);
    return digit_glyph(4'(v % 6'd10));
  endfunction

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    idx_q, idx_d;
  page_e         page_q, page_d, snap_page_q, snap_page_d;
  logic          btn_prev_q;
  logic [5:0]    snap_hour_q, snap_min_q, snap_sec_q, snap_wh_q, snap_wm_q, snap_hand_q;
  logic [5:0]    snap_hour_d, snap_min_d, snap_sec_d, snap_wh_d, snap_wm_d, snap_hand_d;
  logic [3:0]    snap_lvl_q, snap_lvl_d;
  logic [7:0]    an_q, an_d, seg_q, seg_d;
  logic          tc, frame_start, btn_rise, blink_blank;
  logic [7:0]    glyph;

`ifdef DISP_REMIND_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          snap_remind_q, snap_remind_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
    snap_remind_d = frame_start ? remind : snap_remind_q;
    blink_blank   = (snap_page_q == PAGE_WORK) && snap_remind_q && blink_phase_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      snap_remind_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      snap_remind_q <= snap_remind_d;
    end
  end
`else
  localparam int unsigned unused_blink_div = BLINK_DIV;
  logic unused_remind;
  assign unused_remind = remind;
  assign blink_blank   = 1'b0;
`endif

  always_comb begin
    tc          = (div_cnt_q == DW'(SCAN_DIV - 1));
    div_cnt_d   = tc ? '0 : div_cnt_q + 1'b1;
    idx_d       = tc ? idx_q + 3'd1 : idx_q;
    frame_start = tc && (idx_q == 3'd7);
    btn_rise    = btn_page && !btn_prev_q;

    page_d = page_q;
    if (btn_rise) begin
      case (page_q)
        PAGE_CLOCK: page_d = PAGE_WORK;
        PAGE_WORK:  page_d = PAGE_HAND;
        default:    page_d = PAGE_CLOCK;
      endcase
    end

    // Snapshot samples page_q, so an edge on the frame-start cycle lands next frame.
    snap_page_d = frame_start ? page_q          : snap_page_q;
    snap_hour_d = frame_start ? cur_hour        : snap_hour_q;
    snap_min_d  = frame_start ? cur_min         : snap_min_q;
    snap_sec_d  = frame_start ? cur_second      : snap_sec_q;
    snap_wh_d   = frame_start ? work_hours      : snap_wh_q;
    snap_wm_d   = frame_start ? work_minutes    : snap_wm_q;
    snap_lvl_d  = frame_start ? state_smoke_lvl : snap_lvl_q;
    snap_hand_d = frame_start ? hand_time       : snap_hand_q;
  end

  always_comb begin
    glyph = GLYPH_BLANK;
    case (snap_page_q)
      PAGE_CLOCK:
        case (idx_q)
          3'd7: glyph = tens_glyph(snap_hour_q);
          3'd6: glyph = ones_glyph(snap_hour_q);
          3'd4: glyph = tens_glyph(snap_min_q);
          3'd3: glyph = ones_glyph(snap_min_q);
          3'd1: glyph = tens_glyph(snap_sec_q);
          3'd0: glyph = ones_glyph(snap_sec_q);
          default: glyph = GLYPH_DASH;
        endcase
      PAGE_WORK:
        case (idx_q)
          3'd7: glyph = tens_glyph(snap_wh_q);
          3'd6: glyph = ones_glyph(snap_wh_q);
          3'd5: glyph = GLYPH_DASH;
          3'd4: glyph = tens_glyph(snap_wm_q);
          3'd3: glyph = ones_glyph(snap_wm_q);
          3'd1: glyph = GLYPH_L;
          3'd0: glyph = digit_glyph(snap_lvl_q);
          default: glyph = GLYPH_BLANK;
        endcase
      PAGE_HAND:
        case (idx_q)
          3'd7: glyph = GLYPH_H;
          3'd1: glyph = tens_glyph(snap_hand_q);
          3'd0: glyph = ones_glyph(snap_hand_q);
          default: glyph = GLYPH_BLANK;
        endcase
      default: glyph = GLYPH_BLANK;
    endcase

    an_d  = '0;
    seg_d = '0;
    if (power_on) begin
      seg_d = glyph;
      if (!blink_blank) an_d = 8'b1 << idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      idx_q       <= '0;
      page_q      <= PAGE_CLOCK;
      btn_prev_q  <= btn_page;
      snap_page_q <= PAGE_CLOCK;
      snap_hour_q <= '0;
      snap_min_q  <= '0;
      snap_sec_q  <= '0;
      snap_wh_q   <= '0;
      snap_wm_q   <= '0;
      snap_lvl_q  <= '0;
      snap_hand_q <= '0;
      an_q        <= '0;
      seg_q       <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      page_q      <= page_d;
      btn_prev_q  <= btn_page;
      snap_page_q <= snap_page_d;
      snap_hour_q <= snap_hour_d;
      snap_min_q  <= snap_min_d;
      snap_sec_q  <= snap_sec_d;
      snap_wh_q   <= snap_wh_d;
      snap_wm_q   <= snap_wm_d;
      snap_lvl_q  <= snap_lvl_d;
      snap_hand_q <= snap_hand_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
endmodule

// File: tb/tb_hood_display_driver.sv
// Bench for hood_display_driver: directed test-plan sequences plus random stimulus,
// every cycle compared against an arithmetic model of the display.
module tb_hood_display_driver;
  localparam int unsigned S = 4;
  localparam int unsigned B = 64;
  localparam int unsigned F = 8 * S;

  localparam logic [7:0] GLYPH [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  logic       clk = 1'b0;
  logic       reset, power_on, btn_page, remind;
  logic [5:0] cur_hour, cur_min, cur_second, work_hours, work_minutes, hand_time;
  logic [3:0] state_smoke_lvl;
  logic [7:0] an, seg;

  always #5 clk = ~clk;

  hood_display_driver #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk(clk), .reset(reset), .power_on(power_on), .btn_page(btn_page),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_second(cur_second),
    .work_hours(work_hours), .work_minutes(work_minutes),
    .state_smoke_lvl(state_smoke_lvl), .hand_time(hand_time), .remind(remind),
    .an(an), .seg(seg)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %02h expected %02h", tag, $time, got, exp);
  endtask

  // Model: cycle count since reset release plus the values captured at each frame start.
  int unsigned m_n;
  int          m_page;
  bit          m_btn_prev;
  int          s_h, s_m, s_s, s_wh, s_wm, s_lvl, s_hand, s_page;
  bit          s_rem;
  logic [7:0]  exp_an, exp_seg;

  function automatic logic [7:0] expect_glyph(input int pg, input int pos);
    logic [7:0] lay [8];
    case (pg)
      0: lay = '{GLYPH[s_h/10], GLYPH[s_h%10], 8'h40, GLYPH[s_m/10], GLYPH[s_m%10],
                 8'h40, GLYPH[s_s/10], GLYPH[s_s%10]};
      1: lay = '{GLYPH[s_wh/10], GLYPH[s_wh%10], 8'h40, GLYPH[s_wm/10], GLYPH[s_wm%10],
                 8'h00, 8'h38, GLYPH[s_lvl]};
      default: lay = '{8'h76, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                       GLYPH[s_hand/10], GLYPH[s_hand%10]};
    endcase
    return lay[7 - pos];
  endfunction

  task automatic model_step();
    int pos;
    bit blank;
    if (reset) begin
      m_n = 0; m_page = 0; m_btn_prev = btn_page;
      s_h = 0; s_m = 0; s_s = 0; s_wh = 0; s_wm = 0; s_lvl = 0; s_hand = 0; s_page = 0; s_rem = 0;
      exp_an = 8'h00; exp_seg = 8'h00;
    end else begin
      pos = int'((m_n / S) % 8);
      blank = 1'b0;
`ifdef DISP_REMIND_BLINK_EN
      blank = (s_page == 1) && s_rem && ((m_n / B) % 2 == 1);
`endif
      exp_seg = power_on ? expect_glyph(s_page, pos) : 8'h00;
      exp_an  = (power_on && !blank) ? 8'(1 << pos) : 8'h00;
      if (m_n % F == F - 1) begin
        s_h = int'(cur_hour); s_m = int'(cur_min); s_s = int'(cur_second);
        s_wh = int'(work_hours); s_wm = int'(work_minutes); s_lvl = int'(state_smoke_lvl);
        s_hand = int'(hand_time); s_rem = remind; s_page = m_page;
      end
      if (btn_page && !m_btn_prev) m_page = (m_page + 1) % 3;
      m_btn_prev = btn_page;
      m_n++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("an", an, exp_an);
    check_eq("seg", seg, exp_seg);
  endtask

  task automatic run(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) tick();
  endtask

  task automatic press();
    btn_page = 1'b1; run(2);
    btn_page = 1'b0; run(2);
  endtask

  initial begin
    reset = 1'b1; power_on = 1'b1; btn_page = 1'b0; remind = 1'b0;
    cur_hour = 6'd12; cur_min = 6'd34; cur_second = 6'd56;
    work_hours = 6'd7; work_minutes = 6'd45; state_smoke_lvl = 4'hB; hand_time = 6'd30;
    run(2);
    reset = 1'b0;
    run(3 * F);
    press(); press();
    run(2 * F);
    press();
    run(2 * F);
    press();
    cur_hour = 6'd63; cur_min = 6'd0; cur_second = 6'd5; hand_time = 6'd63;
    run(F + 5);
    cur_second = 6'd6;
    run(2 * F);
    press();
    remind = 1'b1;
    run(F + 5 * B);
    power_on = 1'b0; run(F);
    power_on = 1'b1; run(F);
    press();
    run(F + 5 * S + 2);
    btn_page = 1'b1; reset = 1'b1; run(2);
    reset = 1'b0; run(F);
    btn_page = 1'b0; run(F);

    for (int unsigned i = 0; i < 4000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 999);
      reset = (r == 7);
      if (r < 30) btn_page = ~btn_page;
      else if (r < 34) power_on = ~power_on;
      else if (r < 38) remind = ~remind;
      else if (r < 60) begin
        cur_hour = 6'($urandom_range(0, 63)); cur_min = 6'($urandom_range(0, 63));
        cur_second = 6'($urandom_range(0, 63)); work_hours = 6'($urandom_range(0, 63));
        work_minutes = 6'($urandom_range(0, 63)); hand_time = 6'($urandom_range(0, 63));
        state_smoke_lvl = 4'($urandom_range(0, 15));
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
